// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// Handshake: imem_req_o stays high with imem_addr_o stable until the cycle imem_ack_i=1; imem_rdata_i is valid only in that cycle.
interface fetch_stage_if #(
   parameter int PC_WIDTH = 32
);
   logic                imem_req_o;
   logic [PC_WIDTH-1:0] imem_addr_o;
   logic                imem_ack_i;
   logic [31:0]         imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: IDLE/REQ/HOLD/DROP FSM, 1-entry skid buffer and IF/ID register.
// Optional stall-cycle counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_stage #(
   parameter int                  PC_WIDTH               = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC               = '0,
   parameter int                  PROC_REGFILE_LOG2_DEEP = 5
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic                              hazard_i,
   input  logic                              redirect_i,
   input  logic [PC_WIDTH-1:0]               redirect_pc_i,
   fetch_stage_if.master                     imem,
   output logic                              if_id_valid_o,
   output logic [31:0]                       if_id_instr_o,
   output logic [PC_WIDTH-1:0]               if_id_pc_o,
   output logic [PROC_REGFILE_LOG2_DEEP-1:0] id_rs1_o,
   output logic [PROC_REGFILE_LOG2_DEEP-1:0] id_rs2_o,
   output logic [31:0]                       stall_cnt_o,
   output logic [1:0]                        dbg_state_o
);

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_REQ  = 2'd1;
   localparam logic [1:0]  ST_HOLD = 2'd2;
   localparam logic [1:0]  ST_DROP = 2'd3;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic [1:0]          state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] drop_addr_q, drop_addr_d;
   logic                ifid_valid_q, ifid_valid_d;
   logic [31:0]         ifid_instr_q, ifid_instr_d;
   logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
   logic                skid_valid_q, skid_valid_d;
   logic [31:0]         skid_instr_q, skid_instr_d;
   logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;

   logic req_w;
   logic ack_w;

   assign req_w = (state_q == ST_REQ) || (state_q == ST_DROP);
   assign ack_w = req_w && imem.imem_ack_i;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_addr_d  = drop_addr_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (redirect_i) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP;
         skid_valid_d = 1'b0;
         pc_d         = redirect_pc_i & ~PC_WIDTH'(3);
         // An unacked request must still complete on the bus; its data is thrown away in DROP.
         if (req_w && !ack_w) begin
            state_d = ST_DROP;
            if (state_q == ST_REQ) drop_addr_d = pc_q;
         end else begin
            state_d = ST_REQ;
         end
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
               if (ack_w) begin
                  pc_d = pc_q + PC_WIDTH'(4);
                  if (hazard_i) begin
                     skid_valid_d = 1'b1;
                     skid_instr_d = imem.imem_rdata_i;
                     skid_pc_d    = pc_q;
                     state_d      = ST_HOLD;
                  end else begin
                     ifid_valid_d = 1'b1;
                     ifid_instr_d = imem.imem_rdata_i;
                     ifid_pc_d    = pc_q;
                  end
               end else if (!hazard_i) begin
                  ifid_valid_d = 1'b0;
                  ifid_instr_d = NOP;
               end
            end
            ST_HOLD: begin
               if (!hazard_i) begin
                  ifid_valid_d = skid_valid_q;
                  ifid_instr_d = skid_instr_q;
                  ifid_pc_d    = skid_pc_q;
                  skid_valid_d = 1'b0;
                  state_d      = ST_REQ;
               end
            end
            default: begin
               if (ack_w) state_d = ST_REQ;
               if (!hazard_i) begin
                  ifid_valid_d = 1'b0;
                  ifid_instr_d = NOP;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         drop_addr_q  <= RESET_PC;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP;
         ifid_pc_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= NOP;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_addr_q  <= drop_addr_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard_i && !redirect_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) stall_cnt_q <= '0;
      else          stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

   assign imem.imem_req_o  = req_w;
   assign imem.imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : pc_q;
   assign if_id_valid_o    = ifid_valid_q;
   assign if_id_instr_o    = ifid_instr_q;
   assign if_id_pc_o       = ifid_pc_q;
   assign id_rs1_o         = ifid_valid_q ? PROC_REGFILE_LOG2_DEEP'(ifid_instr_q[19:15]) : '0;
   assign id_rs2_o         = ifid_valid_q ? PROC_REGFILE_LOG2_DEEP'(ifid_instr_q[24:20]) : '0;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: randomized fetch/hazard/redirect/reset stimulus against a program-order
// reference model; accepted fetches are queued and popped when IF/ID presents a new instruction.
module tb_fetch_stage;
   localparam int          PW  = 32;
   localparam logic [31:0] RPC = 32'h0000_0200;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk;
   logic          rst_n;
   logic          hazard;
   logic          redirect;
   logic [PW-1:0] redirect_pc;
   logic          if_id_valid;
   logic [31:0]   if_id_instr;
   logic [PW-1:0] if_id_pc;
   logic [4:0]    id_rs1;
   logic [4:0]    id_rs2;
   logic [31:0]   stall_cnt;
   logic [1:0]    dbg_state;

   fetch_stage_if #(.PC_WIDTH(PW)) bus ();

   fetch_stage #(.PC_WIDTH(PW), .RESET_PC(RPC), .PROC_REGFILE_LOG2_DEEP(5)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .hazard_i(hazard), .redirect_i(redirect),
      .redirect_pc_i(redirect_pc), .imem(bus.master),
      .if_id_valid_o(if_id_valid), .if_id_instr_o(if_id_instr), .if_id_pc_o(if_id_pc),
      .id_rs1_o(id_rs1), .id_rs2_o(id_rs2), .stall_cnt_o(stall_cnt), .dbg_state_o(dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: program-order fetch stream
   logic [63:0]   exp_q[$];
   logic [PW-1:0] m_pc, m_stale_addr;
   logic          m_stale, m_parked, m_idle;
   logic [31:0]   m_stall;
   logic          prev_rst, prev_hz, prev_rd, started;
   logic          snap_valid;
   logic [31:0]   snap_instr;
   logic [PW-1:0] snap_pc;
   logic          exp_req;
   logic [63:0]   e;
   int            total = 0;
   int            bad = 0;
   int            ack_pct[4] = '{90, 50, 70, 30};
   int            hz_pct[4]  = '{10, 40, 25, 5};
   int            rd_pct[4]  = '{3, 8, 15, 5};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] rand_target();
      if ($urandom_range(0, 5) == 0) return 32'hFFFF_FFF0 | PW'($urandom_range(0, 15));
      return PW'($urandom);
   endfunction

   // Advance the model by one clock edge using the inputs that were held during that cycle.
   task automatic model_edge();
      logic req_now;
      req_now = !m_idle && !m_parked;
      if (!rst_n) begin
         m_pc = RPC; m_stale = 1'b0; m_parked = 1'b0; m_idle = 1'b1; m_stall = '0;
         exp_q.delete();
      end else begin
         if (hazard && !redirect && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (redirect) begin
            exp_q.delete();
            if (req_now && !bus.imem_ack_i) begin
               if (!m_stale) begin m_stale = 1'b1; m_stale_addr = m_pc; end
            end else begin
               m_stale = 1'b0;
            end
            m_pc = redirect_pc & ~PW'(3);
            m_parked = 1'b0;
         end else if (m_parked) begin
            if (!hazard) m_parked = 1'b0;
         end else if (req_now && bus.imem_ack_i) begin
            if (m_stale) m_stale = 1'b0;
            else begin
               exp_q.push_back({m_pc, bus.imem_rdata_i});
               m_pc = m_pc + 4;
               if (hazard) m_parked = 1'b1;
            end
         end
         m_idle = 1'b0;
      end
      prev_rst = rst_n; prev_hz = hazard; prev_rd = redirect;
      started = 1'b1;
   endtask

   // driver: apply inputs for one cycle, then update the model after the edge
   task automatic step(input logic r, input logic hz, input logic rd, input logic [PW-1:0] rpc, input logic ack);
      rst_n = r; hazard = hz; redirect = rd; redirect_pc = rpc;
      bus.imem_ack_i = ack; bus.imem_rdata_i = $urandom;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (started) begin
         exp_req = !m_idle && !m_parked;
         chk("imem_req", 64'(bus.imem_req_o), 64'(exp_req));
         if (bus.imem_req_o || !prev_rst)
            chk("imem_addr", 64'(bus.imem_addr_o), 64'(m_stale ? m_stale_addr : m_pc));
         if (!prev_rst) begin
            chk("rst_valid", 64'(if_id_valid), 64'(0));
            chk("rst_instr", 64'(if_id_instr), 64'(NOP));
            chk("rst_pc", 64'(if_id_pc), 64'(0));
            chk("rst_state", 64'(dbg_state), 64'(0));
         end else if (prev_rd) begin
            chk("redirect_valid", 64'(if_id_valid), 64'(0));
            chk("redirect_pc_hold", 64'(if_id_pc), 64'(snap_pc));
         end else if (prev_hz) begin
            chk("hazard_hold_pc", 64'(if_id_pc), 64'(snap_pc));
            chk("hazard_hold_instr", {31'd0, if_id_valid, if_id_instr}, {31'd0, snap_valid, snap_instr});
         end else if (if_id_valid) begin
            chk("entry_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("ifid_entry", {if_id_pc, if_id_instr}, e);
            end
         end else begin
            chk("bubble_pc", 64'(if_id_pc), 64'(snap_pc));
         end
         if (!if_id_valid) chk("bubble_instr", 64'(if_id_instr), 64'(NOP));
         chk("id_rs1", 64'(id_rs1), 64'(if_id_valid ? if_id_instr[19:15] : 5'd0));
         chk("id_rs2", 64'(id_rs2), 64'(if_id_valid ? if_id_instr[24:20] : 5'd0));
`ifdef FETCH_STALL_CNT_EN
         chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
         chk("stall_cnt", 64'(stall_cnt), 64'(0));
`endif
         snap_valid = if_id_valid; snap_instr = if_id_instr; snap_pc = if_id_pc;
      end
   end

   initial begin
      started = 1'b0;
      rst_n = 1'b0; hazard = 1'b0; redirect = 1'b0; redirect_pc = '0;
      bus.imem_ack_i = 1'b0; bus.imem_rdata_i = '0;
      // reset with stray acks
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      // straight-line fetch, ack every cycle
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      // three-cycle hazard with an ack on its first cycle, then release
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      // redirect while a request is pending: stale ack must be dropped
      step(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      // redirect and hazard together
      step(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      // redirect into DROP, second redirect inside DROP, then reset mid-DROP with a late ack
      step(1'b1, 1'b0, 1'b1, 32'h0000_0800, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h0000_0900, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, 1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      // randomized phases
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 99) < hz_pct[p]),
                 ($urandom_range(0, 99) < rd_pct[p]),
                 rand_target(),
                 ($urandom_range(0, 99) < ack_pct[p]));
         end
      end
      // drain: no new acks, no stalls
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      #1;
      chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_WIDTH, default 32, SHALL set the width of the program counter and of all PC ports.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 Parameter PROC_REGFILE_LOG2_DEEP, default 5, SHALL set the width of the rs1/rs2 outputs.
REQ-004 clk_i  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005 rst_n_i  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 hazard_i  in  1  SHALL be the stall request from hazard detection (hold IF/ID).
REQ-007 redirect_i  in  1  SHALL be the flush request for a taken branch, JAL or JALR.
REQ-008 redirect_pc_i  in  PC_WIDTH  SHALL be the redirect target.
REQ-009 imem_req_o  out  1  SHALL be the instruction-memory request.
REQ-010 imem_addr_o  out  PC_WIDTH  SHALL be the request address.
REQ-011 imem_ack_i  in  1  SHALL be the memory response strobe.
REQ-012 imem_rdata_i  in  32  SHALL be the memory read data, valid only when imem_ack_i=1.
REQ-013 if_id_valid_o  out  1  SHALL be the IF/ID valid flag.
REQ-014 if_id_instr_o  out  32  SHALL be the IF/ID instruction.
REQ-015 if_id_pc_o  out  PC_WIDTH  SHALL be the IF/ID PC.
REQ-016 id_rs1_o / id_rs2_o  out  PROC_REGFILE_LOG2_DEEP each  SHALL equal if_id_instr_o[19:15] and [24:20], combinationally, and SHALL be forced to 0 when if_id_valid_o=0.
REQ-017 stall_cnt_o  out  32  SHALL be the stall-cycle counter (see Configuration).

Function
REQ-018 FSM SHALL have four states: IDLE, REQ (request outstanding), HOLD (skid buffer full, no request), and DROP (stale request outstanding after a redirect).
REQ-019 IDLE SHALL last exactly one cycle after reset release and then go to REQ, with imem_req_o=1 and imem_addr_o=RESET_PC.
REQ-020 In REQ and DROP, imem_req_o SHALL stay 1 and imem_addr_o SHALL stay stable until the cycle in which imem_ack_i=1.
REQ-021 REQ with ack, no hazard and no redirect: IF/ID SHALL load {1, rdata, addr} next cycle, PC SHALL advance by 4 (modulo 2^PC_WIDTH), and the next request SHALL issue back-to-back with no idle cycle.
REQ-022 REQ with ack and hazard_i=1: rdata and addr SHALL go to the 1-entry skid buffer, IF/ID SHALL hold, PC SHALL advance by 4, and the next state SHALL be HOLD with imem_req_o=0.
REQ-023 HOLD with hazard_i=0: IF/ID SHALL load from the skid buffer, the skid buffer SHALL be cleared, and the next state SHALL be REQ; HOLD with hazard_i=1 SHALL change nothing.
REQ-024 Any state without ack, hazard_i=1 and no redirect: IF/ID SHALL hold its contents.
REQ-025 REQ without ack, hazard_i=0 and no redirect: IF/ID SHALL become a bubble (valid=0, instr=32'h0000_0013, pc unchanged).
REQ-026 redirect_i=1 in any state: IF/ID SHALL become a bubble, the skid buffer SHALL be cleared, and PC SHALL load {redirect_pc_i[PC_WIDTH-1:2], 2'b00}.
REQ-027 After a redirect, the next state SHALL be DROP if a request was outstanding without ack that cycle, otherwise REQ at the new PC.
REQ-028 DROP SHALL keep the old address on the bus; its ack data SHALL be discarded, and the next state SHALL be REQ at the redirected PC.
REQ-029 Priority SHALL be redirect_i over hazard_i over normal fetch; a redirect arriving while in DROP SHALL update PC and remain in DROP.

Reset
REQ-030 While rst_n_i=0, the block SHALL drive: state=IDLE, PC=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, if_id_valid_o=0, if_id_instr_o=32'h0000_0013, if_id_pc_o=0, skid buffer empty, stall_cnt_o=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; an ack arriving during reset or in IDLE SHALL be ignored.

Configuration
REQ-032 With macro FETCH_STALL_CNT_EN defined, stall_cnt_o SHALL increment in each cycle with hazard_i=1 and redirect_i=0, saturating at 32'hFFFF_FFFF.
REQ-033 Without FETCH_STALL_CNT_EN, stall_cnt_o SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-034 Reset release with ack every cycle and rdata=addr SHALL give imem_addr_o = 0,4,8,... and IF/ID pc 0,4,8 with valid=1 from cycle 2.
REQ-035 hazard_i=1 for 3 cycles while ack arrives at addr 0x8 SHALL hold IF/ID at pc 0x4, put 0x8 in HOLD, and show pc 0x8 the cycle after hazard drops; stall_cnt_o SHALL be 3 when the macro is on.
REQ-036 redirect_i=1 with redirect_pc_i=0x103 while an ack is pending for 0xC SHALL give a bubble, DROP state, 0xC data never appearing on IF/ID, then a request at 0x100.
REQ-037 redirect_i and hazard_i both 1 SHALL give a bubble and PC loaded with the target; the hazard SHALL be ignored.
REQ-038 Deasserting rst_n_i in the middle of a DROP SHALL return the block to the REQ-030 values; a late ack SHALL be ignored and the first request SHALL be at RESET_PC.
